// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage and data memory.
//   req   : request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : store data
//   ack   : memory completes the request this cycle
//   rdata : load data, valid together with ack
// The master modport is the stage side; the slave modport is the memory side.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Takes execute records; non-memory records are forwarded to writeback
// one cycle later, LW/SW records run a req/ack transaction on the data
// memory bus while holding the upstream stage off via ex_ready.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_*                 execute record in; ex_ready = stage can accept
//   dmem (master)        data-memory request/ack bus
//   wb_*                 one-cycle writeback record
//   mem_err              sticky timeout flag; stage is dead until reset
module mem_access_stage #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_write_reg,
    input  logic              ex_load_en,
    input  logic              ex_store_en,
    output logic              ex_ready,
    mem_access_stage_if.master dmem,
    output logic              wb_valid,
    output logic              wb_write_reg,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    // Last wait cycle: after it the counter would reach MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, ERR} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [DATA_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [4:0]        rd_cap_reg, rd_cap_next;
    logic              wr_cap_reg, wr_cap_next;
    logic              wb_valid_reg, wb_valid_next;
    logic              wb_wr_reg, wb_wr_next;
    logic [4:0]        wb_rd_reg, wb_rd_next;
    logic [DATA_W-1:0] wb_data_reg, wb_data_next;
    logic              err_reg, err_next;

    logic is_mem;
    assign is_mem = ex_load_en || ex_store_en;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        req_next      = req_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rd_cap_next   = rd_cap_reg;
        wr_cap_next   = wr_cap_reg;
        wb_valid_next = 1'b0;
        wb_wr_next    = wb_wr_reg;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        err_next      = err_reg;

        case (state_reg)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem) begin
                        state_next  = WAIT_ACK;
                        cnt_next    = '0;
                        req_next    = 1'b1;
                        // Both enables set is treated as a load.
                        we_next     = ex_store_en && !ex_load_en;
                        addr_next   = {ex_res[DATA_W-1:2], 2'b00};
                        wdata_next  = ex_store_data;
                        rd_cap_next = ex_rd;
                        // Stores never write the register file, so fold
                        // that into the captured flag now.
                        wr_cap_next = ex_load_en && ex_write_reg && (ex_rd != 5'd0);
                    end else begin
                        wb_valid_next = 1'b1;
                        wb_wr_next    = ex_write_reg && (ex_rd != 5'd0);
                        wb_rd_next    = ex_rd;
                        wb_data_next  = ex_res;
                    end
                end
            end
            WAIT_ACK: begin
                if (dmem.ack) begin
                    // Ack has priority over a timeout in the same cycle.
                    state_next    = IDLE;
                    cnt_next      = '0;
                    req_next      = 1'b0;
                    wb_valid_next = 1'b1;
                    wb_wr_next    = wr_cap_reg;
                    wb_rd_next    = rd_cap_reg;
                    wb_data_next  = we_reg ? '0 : dmem.rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ERR;
                    cnt_next   = '0;
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ERR: begin
                err_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rd_cap_reg   <= '0;
            wr_cap_reg   <= 1'b0;
            wb_valid_reg <= 1'b0;
            wb_wr_reg    <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rd_cap_reg   <= rd_cap_next;
            wr_cap_reg   <= wr_cap_next;
            wb_valid_reg <= wb_valid_next;
            wb_wr_reg    <= wb_wr_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
            err_reg      <= err_next;
        end
    end

    assign ex_ready     = (state_reg == IDLE) && rst_n;
    assign dmem.req     = req_reg;
    assign dmem.we      = we_reg;
    assign dmem.addr    = addr_reg;
    assign dmem.wdata   = wdata_reg;
    assign wb_valid     = wb_valid_reg;
    assign wb_write_reg = wb_wr_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;
    assign mem_err      = err_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of non-memory records run
// back-to-back, then hand-written LW/SW/timeout/reset sequences.
module tb_mem_access_stage;
    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_res;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_write_reg;
    logic        ex_load_en;
    logic        ex_store_en;
    logic        ex_ready;
    logic        wb_valid;
    logic        wb_write_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    mem_access_stage_if #(.DATA_W(32)) dmem_bus ();

    mem_access_stage #(.DATA_W(32), .MEM_TIMEOUT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_res        (ex_res),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_write_reg  (ex_write_reg),
        .ex_load_en    (ex_load_en),
        .ex_store_en   (ex_store_en),
        .ex_ready      (ex_ready),
        .dmem          (dmem_bus.master),
        .wb_valid      (wb_valid),
        .wb_write_reg  (wb_write_reg),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .mem_err       (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rec(input logic [31:0] res, input logic [31:0] sdata,
                             input logic [4:0] rd, input logic wr,
                             input logic ld, input logic st);
        ex_valid      = 1'b1;
        ex_res        = res;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_write_reg  = wr;
        ex_load_en    = ld;
        ex_store_en   = st;
    endtask

    task automatic idle_in();
        ex_valid    = 1'b0;
        ex_load_en  = 1'b0;
        ex_store_en = 1'b0;
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{res: 32'h0000_0007, rd: 5'd5,  wr: 1'b1, exp_wr: 1'b1};
        vecs[1] = '{res: 32'h1234_5678, rd: 5'd31, wr: 1'b1, exp_wr: 1'b1};
        vecs[2] = '{res: 32'hFFFF_FFFF, rd: 5'd1,  wr: 1'b0, exp_wr: 1'b0};
        vecs[3] = '{res: 32'h0000_0ABC, rd: 5'd0,  wr: 1'b1, exp_wr: 1'b0};
        vecs[4] = '{res: 32'h8000_0001, rd: 5'd17, wr: 1'b1, exp_wr: 1'b1};

        rst_n = 1'b1;
        idle_in();
        ex_res = '0; ex_store_data = '0; ex_rd = '0; ex_write_reg = 1'b0;
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("rst_req", {31'd0, dmem_bus.req}, 32'd0);
        step();
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_addr", dmem_bus.addr, 32'd0);
        check("rst_we", {31'd0, dmem_bus.we}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        // Non-memory records, back-to-back.
        for (int i = 0; i < 5; i++) begin
            drive_rec(vecs[i].res, 32'd0, vecs[i].rd, vecs[i].wr, 1'b0, 1'b0);
            step();
            $display("[TB] alu vec %0d res=0x%08h rd=%0d -> wb_valid=%0b wb_data=0x%08h wr=%0b",
                     i, vecs[i].res, vecs[i].rd, wb_valid, wb_data, wb_write_reg);
            check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
            check("alu_wb_data", wb_data, vecs[i].res);
            check("alu_wb_rd", {27'd0, wb_rd}, {27'd0, vecs[i].rd});
            check("alu_wb_write_reg", {31'd0, wb_write_reg}, {31'd0, vecs[i].exp_wr});
            check("alu_ex_ready", {31'd0, ex_ready}, 32'd1);
        end
        idle_in();
        step();
        check("alu_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

        // LW with two wait cycles before ack.
        drive_rec(32'h0000_0103, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            check("lw_req", {31'd0, dmem_bus.req}, 32'd1);
            check("lw_addr", dmem_bus.addr, 32'h0000_0100);
            check("lw_we", {31'd0, dmem_bus.we}, 32'd0);
            check("lw_ex_ready", {31'd0, ex_ready}, 32'd0);
            check("lw_no_wb", {31'd0, wb_valid}, 32'd0);
            if (k < 2) step();
        end
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'hDEAD_BEEF;
        step();
        dmem_bus.ack = 1'b0;
        dmem_bus.rdata = '0;
        $display("[TB] lw addr=0x100 -> wb_valid=%0b wb_data=0x%08h wr=%0b rd=%0d",
                 wb_valid, wb_data, wb_write_reg, wb_rd);
        check("lw_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
        check("lw_wb_write_reg", {31'd0, wb_write_reg}, 32'd1);
        check("lw_wb_rd", {27'd0, wb_rd}, 32'd3);
        check("lw_req_drop", {31'd0, dmem_bus.req}, 32'd0);
        check("lw_ex_ready_back", {31'd0, ex_ready}, 32'd1);
        step();
        check("lw_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

        // SW with immediate ack.
        drive_rec(32'h0000_0020, 32'h0000_0055, 5'd7, 1'b1, 1'b0, 1'b1);
        step();
        idle_in();
        check("sw_req", {31'd0, dmem_bus.req}, 32'd1);
        check("sw_we", {31'd0, dmem_bus.we}, 32'd1);
        check("sw_wdata", dmem_bus.wdata, 32'h0000_0055);
        check("sw_addr", dmem_bus.addr, 32'h0000_0020);
        dmem_bus.ack = 1'b1;
        step();
        dmem_bus.ack = 1'b0;
        $display("[TB] sw addr=0x20 -> wb_valid=%0b wr=%0b wb_data=0x%08h", wb_valid, wb_write_reg, wb_data);
        check("sw_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("sw_wb_write_reg", {31'd0, wb_write_reg}, 32'd0);
        check("sw_wb_data", wb_data, 32'd0);
        check("sw_req_drop", {31'd0, dmem_bus.req}, 32'd0);
        step();

        // Both enables set: behaves as a load.
        drive_rec(32'h0000_0047, 32'h0000_9999, 5'd9, 1'b1, 1'b1, 1'b1);
        step();
        idle_in();
        check("ldst_we", {31'd0, dmem_bus.we}, 32'd0);
        check("ldst_addr", dmem_bus.addr, 32'h0000_0044);
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h0000_1234;
        step();
        dmem_bus.ack = 1'b0;
        $display("[TB] ld+st addr=0x44 -> wb_data=0x%08h wr=%0b", wb_data, wb_write_reg);
        check("ldst_wb_data", wb_data, 32'h0000_1234);
        check("ldst_wb_write_reg", {31'd0, wb_write_reg}, 32'd1);
        step();

        // Ack on the last allowed wait cycle beats the timeout.
        drive_rec(32'h0000_0300, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        for (int k = 0; k < 15; k++) step();
        check("late_ok_req", {31'd0, dmem_bus.req}, 32'd1);
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h0000_CAFE;
        step();
        dmem_bus.ack = 1'b0;
        $display("[TB] lw ack on cycle 16 -> wb_valid=%0b mem_err=%0b", wb_valid, mem_err);
        check("late_ok_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("late_ok_wb_data", wb_data, 32'h0000_CAFE);
        check("late_ok_mem_err", {31'd0, mem_err}, 32'd0);
        step();

        // Timeout: 16 request cycles without ack, then ERR.
        drive_rec(32'h0000_0200, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        for (int k = 0; k < 16; k++) begin
            check("to_req_held", {31'd0, dmem_bus.req}, 32'd1);
            step();
        end
        $display("[TB] lw timeout -> req=%0b mem_err=%0b ex_ready=%0b", dmem_bus.req, mem_err, ex_ready);
        check("to_req_drop", {31'd0, dmem_bus.req}, 32'd0);
        check("to_mem_err", {31'd0, mem_err}, 32'd1);
        check("to_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("to_no_wb", {31'd0, wb_valid}, 32'd0);
        dmem_bus.ack = 1'b1;
        dmem_bus.rdata = 32'h0BAD_0BAD;
        drive_rec(32'h0000_0011, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        step();
        dmem_bus.ack = 1'b0;
        idle_in();
        check("err_late_ack_wb", {31'd0, wb_valid}, 32'd0);
        check("err_no_req", {31'd0, dmem_bus.req}, 32'd0);
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        check("err_ex_ready", {31'd0, ex_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("err_rst_mem_err", {31'd0, mem_err}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("err_rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        // Reset in the middle of a load.
        drive_rec(32'h0000_0400, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        idle_in();
        check("mid_req_up", {31'd0, dmem_bus.req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_req_async_drop", {31'd0, dmem_bus.req}, 32'd0);
        dmem_bus.ack = 1'b1;
        step();
        dmem_bus.ack = 1'b0;
        check("mid_no_wb", {31'd0, wb_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        check("mid_no_wb_after", {31'd0, wb_valid}, 32'd0);
        drive_rec(32'h0000_0009, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        $display("[TB] add after reset -> wb_valid=%0b wb_data=0x%08h", wb_valid, wb_data);
        check("mid_add_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("mid_add_wb_data", wb_data, 32'h0000_0009);
        check("mid_add_wb_rd", {27'd0, wb_rd}, 32'd2);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
